// File: rtl/boot_loader.sv
// boot_loader: receives a byte-serial program image (count, payload, XOR
// checksum), writes it word by word into instruction memory and holds the
// core in reset until a complete, checksum-verified image has been loaded.
module boot_loader #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned MAX_WORDS   = 256,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [15:0] im_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam int unsigned     TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]     MAX_N   = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DAT_HI = 3'd2,
    S_DAT_LO = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_hi_q, cnt_hi_d;
  logic [15:0]   count_q, count_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0]   words_q, words_d;
  logic          rx_ready_q, rx_ready_d;
  logic          im_we_q, im_we_d;
  logic [15:0]   im_addr_q, im_addr_d;
  logic [15:0]   im_wdata_q, im_wdata_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          accept_s;
  logic          timed_s;
  logic [15:0]   n_rx_s;

  assign accept_s = rx_valid && rx_ready_q;
  assign timed_s  = (state_q == S_CNT_LO) || (state_q == S_DAT_HI) ||
                    (state_q == S_DAT_LO) || (state_q == S_CHK);
  assign n_rx_s   = {cnt_hi_q, rx_data};

  // Next-state, datapath updates and registered-output decode of the next state.
  always_comb begin
    state_d    = state_q;
    cnt_hi_d   = cnt_hi_q;
    count_d    = count_q;
    hi_d       = hi_q;
    csum_d     = csum_q;
    words_d    = words_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    // Inter-byte timeout: only while a frame is in progress.
    if (timed_s && !accept_s) begin
      to_d = to_q + TW'(1);
    end else begin
      to_d = '0;
    end

    case (state_q)
      S_CNT_HI: begin
        if (accept_s) begin
          cnt_hi_d = rx_data;
          state_d  = S_CNT_LO;
        end else begin
          state_d  = S_CNT_HI;
        end
      end
      S_CNT_LO: begin
        if (accept_s) begin
          count_d = n_rx_s;
          if ({1'b0, n_rx_s} > MAX_N) begin
            state_d = S_ERR;
          end else if (n_rx_s == 16'h0000) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DAT_HI;
          end
        end else begin
          state_d = S_CNT_LO;
        end
      end
      S_DAT_HI: begin
        if (accept_s) begin
          hi_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = S_DAT_LO;
        end else begin
          state_d = S_DAT_HI;
        end
      end
      S_DAT_LO: begin
        if (accept_s) begin
          csum_d     = csum_q ^ rx_data;
          im_we_d    = 1'b1;
          im_wdata_d = {hi_q, rx_data};
          im_addr_d  = BASE_ADDR + {words_q[14:0], 1'b0};
          words_d    = words_q + 16'd1;
          if ((words_q + 16'd1) == count_q) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DAT_HI;
          end
        end else begin
          state_d = S_DAT_LO;
        end
      end
      S_CHK: begin
        if (accept_s) begin
          if (rx_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          state_d = S_CHK;
        end
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_d = S_CNT_HI;
          words_d = 16'h0000;
          csum_d  = 8'h00;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_CNT_HI;
      end
    endcase

    // A stalled frame aborts; an accept in the same cycle never reaches here.
    if (timed_s && !accept_s && (to_q == TO_LAST)) begin
      state_d = S_ERR;
    end else begin
      state_d = state_d;
    end

    rx_ready_d  = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) ||
                  (state_d == S_DAT_HI) || (state_d == S_DAT_LO) ||
                  (state_d == S_CHK);
    cpu_reset_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CNT_HI;
      cnt_hi_q    <= 8'h00;
      count_q     <= 16'h0000;
      hi_q        <= 8'h00;
      csum_q      <= 8'h00;
      to_q        <= '0;
      words_q     <= 16'h0000;
      rx_ready_q  <= 1'b1;
      im_we_q     <= 1'b0;
      im_addr_q   <= BASE_ADDR;
      im_wdata_q  <= 16'h0000;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_hi_q    <= cnt_hi_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      to_q        <= to_d;
      words_q     <= words_d;
      rx_ready_q  <= rx_ready_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader: table of directed frames, hand-written timeout
// and mid-frame reset sequences, then random frames checked against a
// frame-level reference model.
module tb_boot_loader;

  localparam logic [15:0] BASE = 16'h0000;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic        im_we;
  logic [15:0] im_addr;
  logic [15:0] im_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];

  typedef struct {
    logic [55:0] bytes;
    int          len;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_words;
    int          exp_nwr;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t tbl[5];

  boot_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(256),
    .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .reload(reload),
    .im_we(im_we),
    .im_addr(im_addr),
    .im_wdata(im_wdata),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every cycle the write strobe is high.
  always @(negedge clk) begin
    if (im_we) got_q.push_back({im_addr, im_wdata});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    reload   = ($urandom_range(0, 7) == 0);
    @(negedge clk);
    rx_valid = 1'b0;
    reload   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_rx_ready", 32'(rx_ready), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    check("reload_error", 32'(error), 32'd0);
    check("reload_words", 32'(words_loaded), 32'd0);
    got_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_im_we"}, 32'(im_we), 32'd0);
    check({tag, "_im_addr"}, 32'(im_addr), 32'(BASE));
    check({tag, "_im_wdata"}, 32'(im_wdata), 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    int cyc;
    int n;
    logic corrupt;
    logic [7:0] x;
    logic [15:0] w;
    logic exp_ok;

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    @(negedge clk);
    got_q.delete();

    // Directed frames: {bytes, len, done, err, words, nwrites, first, last}
    tbl[0] = '{56'h00_02_12_34_AB_CD_40, 7, 1'b1, 1'b0, 16'd2, 2, 32'h0000_1234, 32'h0002_ABCD};
    tbl[1] = '{56'h00_02_12_34_AB_CD_41, 7, 1'b0, 1'b1, 16'd2, 2, 32'h0000_1234, 32'h0002_ABCD};
    tbl[2] = '{56'h00_02_12_34_AB_CD_40, 7, 1'b1, 1'b0, 16'd2, 2, 32'h0000_1234, 32'h0002_ABCD};
    tbl[3] = '{56'h00_00_00_00_00_00_00, 3, 1'b1, 1'b0, 16'd0, 0, 32'h0, 32'h0};
    tbl[4] = '{56'h01_01_00_00_00_00_00, 2, 1'b0, 1'b1, 16'd0, 0, 32'h0, 32'h0};

    for (int t = 0; t < 5; t++) begin
      logic [55:0] bv;
      bv = tbl[t].bytes;
      for (int i = 0; i < tbl[t].len; i++) send_byte(bv[55 - 8*i -: 8], 0);
      check($sformatf("tbl%0d_done", t), 32'(done), 32'(tbl[t].exp_done));
      check($sformatf("tbl%0d_error", t), 32'(error), 32'(tbl[t].exp_err));
      check($sformatf("tbl%0d_cpu_reset", t), 32'(cpu_reset), 32'(!tbl[t].exp_done));
      check($sformatf("tbl%0d_rx_ready", t), 32'(rx_ready), 32'd0);
      check($sformatf("tbl%0d_words", t), 32'(words_loaded), 32'(tbl[t].exp_words));
      check($sformatf("tbl%0d_nwr", t), 32'(got_q.size()), 32'(tbl[t].exp_nwr));
      if (tbl[t].exp_nwr > 0 && got_q.size() > 0) begin
        check($sformatf("tbl%0d_first_wr", t), got_q[0], tbl[t].exp_first);
        check($sformatf("tbl%0d_last_wr", t), got_q[got_q.size()-1], tbl[t].exp_last);
      end
      pulse_reload();
    end

    // Timeout: error exactly 1024 cycles after the last accept, no writes.
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    cyc = 0;
    while (!error && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_cycles", 32'(cyc), 32'd1024);
    check("timeout_error", 32'(error), 32'd1);
    check("timeout_nwr", 32'(got_q.size()), 32'd0);
    pulse_reload();

    // Reset mid-frame, then a valid frame sent every other cycle.
    send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h12, 0);
    send_byte(8'h34, 0); send_byte(8'hAB, 0);
    check("midrst_pre_words", 32'(words_loaded), 32'd1);
    reset = 1'b1;
    reload = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    reload = 1'b0;
    check_reset_values("midrst");
    got_q.delete();
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    foreach (tx_q[i]) send_byte(tx_q[i], 1);
    check("midrst_done", 32'(done), 32'd1);
    check("midrst_words", 32'(words_loaded), 32'd2);
    check("midrst_nwr", 32'(got_q.size()), 32'd2);
    pulse_reload();

    // Random frames against a frame-level model.
    for (int f = 0; f < 25; f++) begin
      if (f == 0) n = 256;
      else if ($urandom_range(0, 7) == 0) n = 257 + $urandom_range(0, 1000);
      else n = $urandom_range(0, 6);
      corrupt = ($urandom_range(0, 3) == 0);
      tx_q.delete(); exp_q.delete();
      tx_q.push_back(8'(n >> 8));
      tx_q.push_back(8'(n));
      x = 8'h00;
      if (n <= 256) begin
        for (int k = 0; k < n; k++) begin
          w = 16'($urandom);
          tx_q.push_back(w[15:8]);
          tx_q.push_back(w[7:0]);
          x = x ^ w[15:8] ^ w[7:0];
          exp_q.push_back({16'(BASE + 16'(2*k)), w});
        end
        tx_q.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
      end
      exp_ok = (n <= 256) && !corrupt;
      foreach (tx_q[i]) send_byte(tx_q[i], $urandom_range(0, 2));
      check($sformatf("rnd%0d_done", f), 32'(done), 32'(exp_ok));
      check($sformatf("rnd%0d_error", f), 32'(error), 32'(!exp_ok));
      check($sformatf("rnd%0d_cpu_reset", f), 32'(cpu_reset), 32'(!exp_ok));
      check($sformatf("rnd%0d_words", f), 32'(words_loaded), (n <= 256) ? 32'(n) : 32'd0);
      check($sformatf("rnd%0d_nwr", f), 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        if (got_q[i] !== exp_q[i]) check($sformatf("rnd%0d_wr%0d", f, i), got_q[i], exp_q[i]);
      end
      pulse_reload();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
